// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one fixed-latency memory port
// between a fetch requester (I) and a data requester (D).
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_gnt_d;
  logic        r_last_d;
  logic        r_wr;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_idata;
  logic [15:0] r_drdata;
  logic        w_grant;
  logic        w_pick_d;
  logic        w_last;

  // On a tie, D wins unless it was the most recent grant.
  always_comb begin
    w_pick_d = d_req & (~i_req | ~r_last_d);
    w_grant  = (r_state == IDLE) & (i_req | d_req);
    w_last   = (r_cnt == 4'd0);
    w_next   = r_state;
    unique case (r_state)
      IDLE:    if (w_grant) w_next = BUSY;
      BUSY:    if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_gnt_d  <= 1'b0;
      r_last_d <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= 16'h0;
      r_wdata  <= 16'h0;
      r_idata  <= 16'h0;
      r_drdata <= 16'h0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_gnt_d  <= w_pick_d;
        r_last_d <= w_pick_d;
        r_addr   <= w_pick_d ? d_addr : i_addr;
        r_wr     <= w_pick_d & d_wr;
        r_wdata  <= w_pick_d ? d_wdata : 16'h0;
        r_cnt    <= CNT_INIT;
      end else if (r_state == BUSY) begin
        if (!w_last) begin
          r_cnt <= r_cnt - 4'd1;
        end else if (!r_wr) begin
          if (r_gnt_d) r_drdata <= mem_rdata;
          else         r_idata  <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (r_state == BUSY);
  assign mem_wr    = mem_en & r_wr;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != IDLE);
  assign i_done    = (r_state == DONE) & ~r_gnt_d;
  assign d_done    = (r_state == DONE) & r_gnt_d;
  assign i_stall   = i_req & ~i_done;
  assign d_stall   = d_req & ~d_done;
  assign i_data    = r_idata;
  assign d_rdata   = r_drdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// against a memory model and a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] mem_rdata1;

  logic [15:0] i_data, d_rdata, mem_addr, mem_wdata;
  logic        i_done, i_stall, d_done, d_stall;
  logic        mem_en, mem_wr, busy;
  logic [15:0] i_data1, d_rdata1, mem_addr1, mem_wdata1;
  logic        i_done1, i_stall1, d_done1, d_stall1;
  logic        mem_en1, mem_wr1, busy1;

  int total = 0;
  int bad = 0;

  mem_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_data(i_data), .i_done(i_done),
    .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_data(i_data1), .i_done(i_done1),
    .i_stall(i_stall1),
    .d_req(d_req), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_done(d_done1),
    .d_stall(d_stall1),
    .mem_en(mem_en1), .mem_wr(mem_wr1),
    .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: data is only valid in the final access cycle.
  logic [15:0] mem [logic [15:0]];
  logic [15:0] exp_mem [logic [15:0]];
  int run = 0;

  function automatic logic [15:0] init_val(
    input logic [15:0] a);
    if (a == 16'h0010) return 16'hA5A5;
    if (a == 16'h0050) return 16'hBEEF;
    return a ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] rd_mem(
    input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  function automatic logic [15:0] exp_val(
    input logic [15:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_wr && run == LAT - 1)
      mem[mem_addr] = mem_wdata;
    run <= mem_en ? run + 1 : 0;
  end

  initial begin
    mem_rdata = 16'h0;
    mem_rdata1 = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = (mem_en && run == LAT - 1) ?
                  rd_mem(mem_addr) : 16'hBAD0;
      mem_rdata1 = mem_en1 ?
                   init_val(mem_addr1) : 16'hBAD1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    d_wr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 1'b1;
    d_req = 1'b1;
    i_addr = 16'h1111;
    d_addr = 16'h2222;
    d_wr = 1'b1;
    d_wdata = 16'h3333;
    repeat (3) begin
      tick();
      @(negedge clk);
      total++;
      if ({mem_en, mem_wr, busy, i_done, d_done}
          !== 5'b0) begin
        bad++;
        $display("FAIL reset_ctl: got %b want 00000",
          {mem_en, mem_wr, busy, i_done, d_done});
      end
      total++;
      if ({i_data, d_rdata, mem_addr, mem_wdata}
          !== 64'h0) begin
        bad++;
        $display("FAIL reset_data: got %h want 0",
          {i_data, d_rdata, mem_addr, mem_wdata});
      end
    end
    tick();
    rst = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    d_wr = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_en, mem_wr, busy, i_done, d_done,
         mem_en1, busy1} !== 7'b0) begin
      bad++;
      $display("FAIL post_reset: got %b want 0",
        {mem_en, mem_wr, busy, i_done, d_done,
         mem_en1, busy1});
    end
  endtask

  task automatic test_fetch();
    do_reset();
    i_req = 1'b1;
    i_addr = 16'h0010;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (mem_en !== (c >= 1 && c <= 4)) begin
        bad++;
        $display("FAIL fetch_en c=%0d: got %b", c, mem_en);
      end
      total++;
      if (i_done !== (c == 5) || d_done !== 1'b0) begin
        bad++;
        $display("FAIL fetch_done c=%0d: got %b%b",
          c, i_done, d_done);
      end
      total++;
      if (i_stall !== (c < 5) || busy !== (c >= 1 && c <= 5)) begin
        bad++;
        $display("FAIL fetch_stall c=%0d: got %b%b",
          c, i_stall, busy);
      end
      if (c >= 1 && c <= 4) begin
        total++;
        if (mem_addr !== 16'h0010 || mem_wr !== 1'b0) begin
          bad++;
          $display("FAIL fetch_addr: got %h %b want 0010 0",
            mem_addr, mem_wr);
        end
      end
      if (c == 5) begin
        total++;
        if (i_data !== 16'hA5A5) begin
          bad++;
          $display("FAIL fetch_data: got %h want a5a5", i_data);
        end
      end
      tick();
      if (c == 5) i_req = 1'b0;
    end
  endtask

  task automatic test_tie();
    do_reset();
    i_req = 1'b1;
    i_addr = 16'h0020;
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h0030;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      total++;
      if (d_done !== (c == 5) || i_done !== (c == 11)) begin
        bad++;
        $display("FAIL tie_done c=%0d: got i%b d%b",
          c, i_done, d_done);
      end
      total++;
      if (mem_en !== ((c >= 1 && c <= 4) ||
                      (c >= 7 && c <= 10))) begin
        bad++;
        $display("FAIL tie_en c=%0d: got %b", c, mem_en);
      end
      if (c == 5) begin
        total++;
        if (d_rdata !== exp_val(16'h0030)) begin
          bad++;
          $display("FAIL tie_d_data: got %h want %h",
            d_rdata, exp_val(16'h0030));
        end
      end
      if (c == 11) begin
        total++;
        if (i_data !== exp_val(16'h0020)) begin
          bad++;
          $display("FAIL tie_i_data: got %h want %h",
            i_data, exp_val(16'h0020));
        end
      end
      tick();
      if (c == 5) d_req = 1'b0;
      if (c == 11) i_req = 1'b0;
    end
  endtask

  task automatic test_write();
    logic [15:0] prev;
    prev = exp_val(16'h0030);
    d_req = 1'b1;
    d_wr = 1'b1;
    d_addr = 16'h0100;
    d_wdata = 16'h1234;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++;
      if (mem_en !== (c >= 1 && c <= 4) ||
          d_done !== (c == 5)) begin
        bad++;
        $display("FAIL wr_timing c=%0d: got en%b d%b",
          c, mem_en, d_done);
      end
      if (c >= 1 && c <= 4) begin
        total++;
        if ({mem_wr, mem_addr, mem_wdata} !==
            {1'b1, 16'h0100, 16'h1234}) begin
          bad++;
          $display("FAIL wr_bus: got %b %h %h",
            mem_wr, mem_addr, mem_wdata);
        end
      end
      if (c == 5) begin
        total++;
        if (d_rdata !== prev) begin
          bad++;
          $display("FAIL wr_rdata: got %h want %h",
            d_rdata, prev);
        end
      end
      tick();
      if (c == 5) begin
        d_req = 1'b0;
        d_wr = 1'b0;
      end
    end
    exp_mem[16'h0100] = 16'h1234;
    d_req = 1'b1;
    d_addr = 16'h0100;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 5) begin
        total++;
        if (d_done !== 1'b1 ||
            d_rdata !== exp_val(16'h0100)) begin
          bad++;
          $display("FAIL wr_readback: got %b %h want 1 %h",
            d_done, d_rdata, exp_val(16'h0100));
        end
      end
      tick();
      if (c == 5) d_req = 1'b0;
    end
  endtask

  task automatic test_alternate();
    do_reset();
    i_req = 1'b1;
    i_addr = 16'h0020;
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h0030;
    for (int c = 0; c < 36; c++) begin
      int ph;
      int slot;
      ph = c % 6;
      slot = c / 6;
      @(negedge clk);
      total++;
      if (d_done !== (ph == 5 && slot % 2 == 0) ||
          i_done !== (ph == 5 && slot % 2 == 1)) begin
        bad++;
        $display("FAIL alt_done c=%0d: got i%b d%b",
          c, i_done, d_done);
      end
      total++;
      if (mem_en !== (ph >= 1 && ph <= 4)) begin
        bad++;
        $display("FAIL alt_en c=%0d: got %b", c, mem_en);
      end
      tick();
      if (c == 35) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    i_req = 1'b1;
    i_addr = 16'h0040;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0040) begin
      bad++;
      $display("FAIL mid_busy: got %b %h want 1 0040",
        mem_en, mem_addr);
    end
    tick();
    rst = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_en, busy, i_done, d_done} !== 4'b0) begin
      bad++;
      $display("FAIL mid_ctl: got %b want 0000",
        {mem_en, busy, i_done, d_done});
    end
    total++;
    if ({i_data, d_rdata, mem_addr, mem_wdata}
        !== 64'h0) begin
      bad++;
      $display("FAIL mid_data: got %h want 0",
        {i_data, d_rdata, mem_addr, mem_wdata});
    end
    repeat (7) begin
      tick();
      @(negedge clk);
      total++;
      if ({i_done, d_done, mem_en} !== 3'b0) begin
        bad++;
        $display("FAIL mid_quiet: got %b want 000",
          {i_done, d_done, mem_en});
      end
    end
    tick();
    i_req = 1'b1;
    i_addr = 16'h0041;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      total++;
      if (i_done !== (c == 5)) begin
        bad++;
        $display("FAIL mid_redo c=%0d: got %b", c, i_done);
      end
      if (c == 5) begin
        total++;
        if (i_data !== exp_val(16'h0041)) begin
          bad++;
          $display("FAIL mid_redo_data: got %h want %h",
            i_data, exp_val(16'h0041));
        end
      end
      tick();
      if (c == 5) i_req = 1'b0;
    end
  endtask

  task automatic test_lat1();
    do_reset();
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h0050;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (mem_en1 !== (c == 1) || d_done1 !== (c == 2) ||
          busy1 !== (c == 1 || c == 2)) begin
        bad++;
        $display("FAIL lat1 c=%0d: got en%b d%b b%b",
          c, mem_en1, d_done1, busy1);
      end
      if (c == 2) begin
        total++;
        if (d_rdata1 !== 16'hBEEF) begin
          bad++;
          $display("FAIL lat1_data: got %h want beef",
            d_rdata1);
        end
      end
      tick();
      if (c == 2) d_req = 1'b0;
    end
  endtask

  task automatic test_random();
    bit i_fin;
    bit d_fin;
    i_fin = 1'b0;
    d_fin = 1'b0;
    do_reset();
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          logic [15:0] a;
          bit got;
          repeat ($urandom_range(0, 2)) tick();
          a = 16'($urandom_range(0, 7));
          i_req = 1'b1;
          i_addr = a;
          got = 1'b0;
          for (int w = 0; w < 60 && !got; w++) begin
            @(negedge clk);
            if (i_done) got = 1'b1;
          end
          total++;
          if (!got) begin
            bad++;
            $display("FAIL rnd_i_timeout: got none want done");
          end else if (i_data !== exp_val(a)) begin
            bad++;
            $display("FAIL rnd_i_data: got %h want %h",
              i_data, exp_val(a));
          end
          tick();
          i_req = 1'b0;
        end
        i_fin = 1'b1;
      end
      begin
        logic [15:0] drd;
        drd = 16'h0;
        for (int n = 0; n < 20; n++) begin
          logic [15:0] a;
          logic [15:0] wd;
          bit wr;
          bit got;
          repeat ($urandom_range(0, 2)) tick();
          a = 16'($urandom_range(0, 7));
          wd = 16'($urandom);
          wr = ($urandom_range(0, 2) == 0);
          d_req = 1'b1;
          d_wr = wr;
          d_addr = a;
          d_wdata = wd;
          got = 1'b0;
          for (int w = 0; w < 60 && !got; w++) begin
            @(negedge clk);
            if (d_done) got = 1'b1;
          end
          if (got && !wr) drd = exp_val(a);
          total++;
          if (!got) begin
            bad++;
            $display("FAIL rnd_d_timeout: got none want done");
          end else if (d_rdata !== drd) begin
            bad++;
            $display("FAIL rnd_d_data: got %h want %h",
              d_rdata, drd);
          end
          if (got && wr) exp_mem[a] = wd;
          tick();
          d_req = 1'b0;
          d_wr = 1'b0;
        end
        d_fin = 1'b1;
      end
      begin
        bit pend;
        bit pend_d;
        bit last_d;
        int g_cyc;
        int cyc;
        pend = 1'b0;
        pend_d = 1'b0;
        last_d = 1'b0;
        g_cyc = 0;
        cyc = 0;
        while (!(i_fin && d_fin) && cyc < 4000) begin
          @(negedge clk);
          total++;
          if (i_done && d_done) begin
            bad++;
            $display("FAIL rnd_both_done: got 11 want not");
          end
          if (pend) begin
            if (i_done || d_done) begin
              total++;
              if (d_done !== pend_d ||
                  cyc - g_cyc != LAT + 1) begin
                bad++;
                $display("FAIL rnd_order: got d%b @%0d want d%b @%0d",
                  d_done, cyc, pend_d, g_cyc + LAT + 1);
              end
              pend = 1'b0;
            end
          end else if (!busy && (i_req || d_req)) begin
            pend_d = d_req && (!i_req || !last_d);
            last_d = pend_d;
            g_cyc = cyc;
            pend = 1'b1;
          end
          cyc++;
        end
        total++;
        if (cyc >= 4000) begin
          bad++;
          $display("FAIL rnd_budget: got %0d cycles", cyc);
        end
      end
    join
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_req = 1'b0;
    i_addr = 16'h0;
    d_req = 1'b0;
    d_wr = 1'b0;
    d_addr = 16'h0;
    d_wdata = 16'h0;
    test_reset();
    test_fetch();
    test_tie();
    test_write();
    test_alternate();
    test_reset_mid();
    test_lat1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 4: backing-memory access latency in cycles; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_req  input  1  fetch-side read request; held high until i_done.
REQ-005 i_addr  input  16  fetch address; sampled only at grant.
REQ-006 i_data  output  16  fetch read data; valid in the i_done cycle, held until next fetch completion.
REQ-007 i_done  output  1  one-cycle fetch completion pulse.
REQ-008 i_stall  output  1  i_req & ~i_done (combinational), drives fetch stop.
REQ-009 d_req  input  1  data-side request; held high until d_done.
REQ-010 d_wr  input  1  1 = write, 0 = read; sampled at grant.
REQ-011 d_addr  input  16  data address; sampled at grant.
REQ-012 d_wdata  input  16  write data; sampled at grant.
REQ-013 d_rdata  output  16  data read result; valid in the d_done cycle, held otherwise.
REQ-014 d_done  output  1  one-cycle data completion pulse.
REQ-015 d_stall  output  1  d_req & ~d_done (combinational).
REQ-016 mem_en  output  1  backing-memory access enable.
REQ-017 mem_wr  output  1  backing-memory write strobe.
REQ-018 mem_addr  output  16  backing-memory address.
REQ-019 mem_wdata  output  16  backing-memory write data.
REQ-020 mem_rdata  input  16  backing-memory read data; valid in the final access cycle.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-023 IDLE, no request: remain in IDLE; mem_en=0, mem_wr=0.
REQ-024 IDLE, one request pending: grant it; latch requester id, address, wr flag and wdata; load cnt=MEM_LAT-1; next state BUSY.
REQ-025 IDLE, both pending: grant the requester not granted last (last_grant toggles round-robin); last_grant resets to I, so D wins the first tie.
REQ-026 last_grant SHALL update only on a grant.
REQ-027 BUSY: mem_en=1; mem_addr/mem_wdata from latched values; mem_wr=latched wr (always 0 for fetch); outputs stable for all MEM_LAT cycles.
REQ-028 BUSY, cnt>0: decrement cnt by 1.
REQ-029 BUSY, cnt==0: capture mem_rdata into i_data or d_rdata (reads only; writes leave d_rdata unchanged); next state DONE.
REQ-030 DONE: assert done for the granted requester for exactly one cycle; mem_en=0; next state IDLE.
REQ-031 Latency: request sampled in IDLE at cycle 0 -> mem_en high cycles 1..MEM_LAT -> done in cycle MEM_LAT+1; next grant possible at cycle MEM_LAT+2.
REQ-032 Requesters SHALL deassert or re-present req in the cycle after done; req seen in IDLE is always a new request.
REQ-033 Request inputs changing during BUSY/DONE SHALL be ignored; no preemption.
REQ-034 MEM_LAT=1: exactly one BUSY cycle, with capture in that cycle.
REQ-035 i_done and d_done SHALL never be high in the same cycle.

Reset
REQ-036 rst high at a clock edge, in any state including mid-BUSY: state=IDLE, cnt=0, last_grant=I, i_data=0, d_rdata=0, latched address/data=0.
REQ-037 While in reset, and in the first cycle after reset: mem_en=0, mem_wr=0, i_done=0, d_done=0, busy=0; any in-flight transaction is abandoned with no done pulse.

Verification
REQ-038 MEM_LAT=4, i_req with i_addr=0x0010, mem_rdata=0xA5A5 in cycle 4 -> mem_en high cycles 1-4 with mem_addr=0x0010, i_done pulse in cycle 5, i_data=0xA5A5.
REQ-039 i_req and d_req both high in cycle 0 after reset -> D served first with d_done in cycle 5; I granted in cycle 6 with i_done in cycle 11.
REQ-040 d_wr=1, d_addr=0x0100, d_wdata=0x1234 -> mem_wr=1, mem_wdata=0x1234 for 4 cycles; d_done in cycle 5; d_rdata unchanged.
REQ-041 Both requests continuously re-presented -> grants alternate D,I,D,I; no requester waits more than one transaction.
REQ-042 rst asserted in BUSY cycle 2 -> next cycle mem_en=0, busy=0, outputs zero; no done pulse; a new i_req then completes normally in MEM_LAT+1 cycles.
REQ-043 MEM_LAT=1, d read with mem_rdata=0xBEEF -> mem_en high cycle 1 only, d_done in cycle 2, d_rdata=0xBEEF.
